// File: rtl/range_counter_if.sv
// -----------------------------------------------------------------------------
// range_counter_if
// Control and status bundle for range_counter. The master side (a controller
// or a testbench) drives the strobes and load data and observes the counter.
// The slave side is the counter itself.
// -----------------------------------------------------------------------------
interface range_counter_if #(
    parameter int WIDTH = 4
);

    // Control strobes and load data
    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             up_down;
    logic             clr_ovf;

    // Counter status
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             in_range;

    modport master (
        output en,
        output load,
        output din,
        output up_down,
        output clr_ovf,
        input  count,
        input  tc,
        input  ovf,
        input  in_range
    );

    modport slave (
        input  en,
        input  load,
        input  din,
        input  up_down,
        input  clr_ovf,
        output count,
        output tc,
        output ovf,
        output in_range
    );

endinterface : range_counter_if

// File: rtl/range_counter.sv
// -----------------------------------------------------------------------------
// range_counter
// Up/down counter confined to the window [MIN_VAL, MAX_VAL].
//  - load copies din straight into the counter, even when din lies outside
//    the window. The next enabled step then pulls the value back into range.
//  - Stepping past a bound either wraps to the opposite bound (SATURATE=0)
//    or holds at the bound (SATURATE=1). Both behaviours raise a one-cycle
//    terminal-count pulse (tc) and set the sticky overflow flag (ovf).
//  - Recovering from an out-of-range value is not a bound event. It raises
//    neither tc nor ovf.
//  - Priority at each rising edge: resetn, then load, then en.
// -----------------------------------------------------------------------------
module range_counter #(
    parameter int WIDTH    = 4,
    parameter int MIN_VAL  = 2,
    parameter int MAX_VAL  = 10,
    parameter int SATURATE = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    range_counter_if.slave        bus
);

    // -------------------------------------------------------------------------
    // Parameter legality. The window must be non-empty and must fit in WIDTH
    // bits. Otherwise elaboration stops here.
    // -------------------------------------------------------------------------
    localparam longint MAX_REPR = (longint'(1) << WIDTH) - 1;

    if (WIDTH < 1 || WIDTH > 62) begin : g_bad_width
        $error("range_counter: WIDTH must be in 1..62");
    end

    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || longint'(MAX_VAL) > MAX_REPR) begin : g_bad_range
        $error("range_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end

    if ($bits(bus.count) != WIDTH) begin : g_bad_bus
        $error("range_counter: interface WIDTH does not match module WIDTH");
    end

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic             SAT   = (SATURATE != 0);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;

    // Next-state signals
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             bound_hit;   // an enabled step ran into a bound

    // Window classification of the current count
    logic below_min;
    logic above_max;
    logic at_min;
    logic at_max;

    assign below_min = (count_q < MIN_V);
    assign above_max = (count_q > MAX_V);
    assign at_min    = (count_q == MIN_V);
    assign at_max    = (count_q == MAX_V);

    // Compute the next count and the terminal-count event from the load/en/direction inputs
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // skips an assignment would otherwise infer a latch.
        count_d   = count_q;
        tc_d      = 1'b0;
        bound_hit = 1'b0;

        if (bus.load) begin
            // Load takes din verbatim. An out-of-range value is corrected by the next step.
            count_d = bus.din;
        end else if (bus.en) begin
            if (!bus.up_down) begin
                // Counting up
                if (below_min || above_max) begin
                    count_d = MIN_V;
                end else if (at_max) begin
                    count_d   = SAT ? MAX_V : MIN_V;
                    tc_d      = 1'b1;
                    bound_hit = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                // Counting down
                if (below_min || above_max) begin
                    count_d = MAX_V;
                end else if (at_min) begin
                    count_d   = SAT ? MIN_V : MAX_V;
                    tc_d      = 1'b1;
                    bound_hit = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Register the count, tc and sticky ovf. Synchronous active-low reset wins over everything.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values and block order cannot matter.
        if (!resetn) begin
            count_q <= MIN_V;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            // A set event in the same cycle as clr_ovf leaves the flag set.
            if (bound_hit) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. in_range is a purely combinational view of the registered count.
    // -------------------------------------------------------------------------
    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.ovf      = ovf_q;
    assign bus.in_range = !below_min && !above_max;

endmodule : range_counter

// File: tb/tb_range_counter.sv
// -----------------------------------------------------------------------------
// tb_range_counter
// Directed bench for range_counter with three instances:
//   u_a : defaults (WIDTH=4, window 2..10, wrapping)
//   u_b : defaults with SATURATE=1
//   u_c : WIDTH=8, window 5..200, wrapping
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, i.e. after the edge that the previous input setup has taken effect on.
// -----------------------------------------------------------------------------
module tb_range_counter;

    logic clock = 1'b0;
    logic resetn_a, resetn_b, resetn_c;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    range_counter_if #(.WIDTH(4)) if_a ();
    range_counter_if #(.WIDTH(4)) if_b ();
    range_counter_if #(.WIDTH(8)) if_c ();

    range_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(10), .SATURATE(0)) u_a (
        .clock (clock), .resetn(resetn_a), .bus(if_a.slave));
    range_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(10), .SATURATE(1)) u_b (
        .clock (clock), .resetn(resetn_b), .bus(if_b.slave));
    range_counter #(.WIDTH(8), .MIN_VAL(5), .MAX_VAL(200), .SATURATE(0)) u_c (
        .clock (clock), .resetn(resetn_c), .bus(if_c.slave));

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic load, input logic [3:0] din,
                           input logic up_down, input logic clr_ovf);
        if_a.en = en; if_a.load = load; if_a.din = din;
        if_a.up_down = up_down; if_a.clr_ovf = clr_ovf;
    endtask

    task automatic drive_b(input logic en, input logic load, input logic [3:0] din,
                           input logic up_down, input logic clr_ovf);
        if_b.en = en; if_b.load = load; if_b.din = din;
        if_b.up_down = up_down; if_b.clr_ovf = clr_ovf;
    endtask

    task automatic drive_c(input logic en, input logic load, input logic [7:0] din,
                           input logic up_down, input logic clr_ovf);
        if_c.en = en; if_c.load = load; if_c.din = din;
        if_c.up_down = up_down; if_c.clr_ovf = clr_ovf;
    endtask

    // Check count, tc and ovf of instance A in one call
    task automatic expect_a(input string tag, input int cnt, input bit tc, input bit ovf);
        check({tag, ".count"}, 32'(if_a.count), 32'(cnt));
        check({tag, ".tc"},    32'(if_a.tc),    32'(tc));
        check({tag, ".ovf"},   32'(if_a.ovf),   32'(ovf));
    endtask

    initial begin
        resetn_a = 1'b0; resetn_b = 1'b0; resetn_c = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        drive_c(0, 0, 0, 0, 0);
        #1;

        // ---------------- Instance A: defaults, wrapping ----------------
        // Reset wins over load and en
        drive_a(1, 1, 7, 0, 0);
        tick();
        expect_a("a_reset", 2, 0, 0);
        check("a_reset.in_range", 32'(if_a.in_range), 32'd1);

        // Count up through the window: 3..10, then wrap to 2 with tc and ovf
        resetn_a = 1'b1;
        drive_a(1, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("a_up%0d.count", i), 32'(if_a.count), (i <= 8) ? 32'(2 + i) : 32'd2);
            check($sformatf("a_up%0d.tc", i),    32'(if_a.tc),    (i == 9) ? 32'd1 : 32'd0);
        end
        check("a_wrap.ovf", 32'(if_a.ovf), 32'd1);
        tick();
        expect_a("a_after_wrap", 3, 0, 1);

        // Load leaves ovf alone. Then a wrap and clr_ovf in the same cycle: ovf stays set.
        drive_a(0, 1, 10, 0, 0);
        tick();
        expect_a("a_load10", 10, 0, 1);
        drive_a(1, 0, 0, 0, 1);
        tick();
        expect_a("a_wrap_clr", 2, 1, 1);
        drive_a(0, 0, 0, 0, 1);
        tick();
        expect_a("a_clr_alone", 2, 0, 0);

        // Out-of-range load above the window, then an up step recovers to MIN silently
        drive_a(0, 1, 15, 0, 0);
        tick();
        expect_a("a_load15", 15, 0, 0);
        check("a_load15.in_range", 32'(if_a.in_range), 32'd0);
        drive_a(1, 0, 0, 0, 0);
        tick();
        expect_a("a_recover_up", 2, 0, 0);

        // Out-of-range load below the window, then a down step recovers to MAX silently
        drive_a(0, 1, 0, 1, 0);
        tick();
        check("a_load0.in_range", 32'(if_a.in_range), 32'd0);
        drive_a(1, 0, 0, 1, 0);
        tick();
        expect_a("a_recover_dn", 10, 0, 0);
        tick();
        expect_a("a_down", 9, 0, 0);

        // Down from MIN wraps to MAX with tc. Direction flip takes effect on the next edge.
        drive_a(0, 1, 2, 1, 0);
        tick();
        drive_a(1, 0, 0, 1, 0);
        tick();
        expect_a("a_dn_wrap", 10, 1, 1);
        drive_a(1, 0, 0, 0, 0);
        tick();
        expect_a("a_flip_up", 2, 1, 1);

        // en low holds the count and drops tc
        drive_a(0, 0, 0, 0, 0);
        tick();
        expect_a("a_hold", 2, 0, 1);

        // Reset in mid-count, together with load: ovf clears, load is ignored
        drive_a(1, 0, 0, 0, 0);
        tick();
        resetn_a = 1'b0;
        drive_a(1, 1, 7, 0, 0);
        tick();
        expect_a("a_reset_load", 2, 0, 0);
        resetn_a = 1'b1;
        drive_a(0, 0, 0, 0, 0);
        tick();
        check("a_rel_hold.count", 32'(if_a.count), 32'd2);
        drive_a(1, 0, 0, 0, 0);
        tick();
        check("a_first_step.count", 32'(if_a.count), 32'd3);

        // ---------------- Instance B: saturating ----------------
        resetn_b = 1'b1;
        drive_b(0, 1, 10, 0, 0);
        tick();
        check("b_load.count", 32'(if_b.count), 32'd10);
        drive_b(1, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("b_sat%0d.count", i), 32'(if_b.count), 32'd10);
            check($sformatf("b_sat%0d.tc", i),    32'(if_b.tc),    32'd1);
        end
        check("b_sat.ovf", 32'(if_b.ovf), 32'd1);
        drive_b(1, 0, 0, 1, 0);
        tick();
        check("b_dn.count", 32'(if_b.count), 32'd9);
        check("b_dn.tc",    32'(if_b.tc),    32'd0);
        drive_b(0, 1, 2, 1, 0);
        tick();
        drive_b(1, 0, 0, 1, 0);
        tick();
        check("b_sat_min.count", 32'(if_b.count), 32'd2);
        check("b_sat_min.tc",    32'(if_b.tc),    32'd1);

        // ---------------- Instance C: 8-bit, window 5..200 ----------------
        resetn_c = 1'b1;
        check("c_reset.count", 32'(if_c.count), 32'd5);
        drive_c(1, 0, 0, 1, 0);
        tick();
        check("c_dn_wrap.count", 32'(if_c.count), 32'd200);
        check("c_dn_wrap.tc",    32'(if_c.tc),    32'd1);
        check("c_dn_wrap.ovf",   32'(if_c.ovf),   32'd1);
        drive_c(1, 1, 77, 1, 0);
        tick();
        check("c_load_wins.count", 32'(if_c.count), 32'd77);
        check("c_load_wins.tc",    32'(if_c.tc),    32'd0);
        drive_c(1, 0, 0, 1, 0);
        tick();
        check("c_down.count", 32'(if_c.count), 32'd76);
        drive_c(0, 1, 250, 0, 0);
        tick();
        check("c_load250.in_range", 32'(if_c.in_range), 32'd0);
        drive_c(1, 0, 0, 0, 0);
        tick();
        check("c_recover.count", 32'(if_c.count), 32'd5);
        check("c_recover.tc",    32'(if_c.tc),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_range_counter
